// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the gated SR latch sequencer.
package sr_latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK
  } state_t;

  localparam logic OP_SET    = 1'b1;
  localparam logic OP_RST    = 1'b0;
  localparam int   ERR_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, favouring the requester not served last.
module sr_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic [1:0] grant
);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequences set/reset writes into a gated SR latch for two requesters and verifies readback.
// Optional SR_LATCH_CTRL_ERR_CNT_EN adds a saturating readback-error counter output.
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic req0_op,
  output logic req0_ready,
  input  logic req1_valid,
  input  logic req1_op,
  output logic req1_ready,
  output logic latch_C,
  output logic latch_S,
  output logic latch_R,
  input  logic latch_Q,
  input  logic latch_Qbar,
  output logic done,
  output logic done_id,
  output logic err,
  output logic q_state
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic             rr_last_q, rr_last_d;
  logic [1:0]       ready_d;
  logic             c_d, s_d, r_d;
  logic             done_d, done_id_d, err_d, q_state_d;
  logic [1:0]       grant;
  logic             sel_op;
  logic             pass;

  sr_rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .rr_last (rr_last_q),
    .grant   (grant)
  );

  assign sel_op = id_q ? req1_op : req0_op;
  assign pass   = (latch_Q == op_q) && (latch_Qbar == ~op_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    id_d      = id_q;
    rr_last_d = rr_last_q;
    ready_d   = 2'b00;
    c_d       = latch_C;
    s_d       = latch_S;
    r_d       = latch_R;
    done_d    = 1'b0;
    done_id_d = done_id;
    err_d     = 1'b0;
    q_state_d = q_state;

    case (state_q)
      IDLE: begin
        // A grant is offered for one cycle; the command is taken only if still valid.
        if (req0_ready || req1_ready) begin
          if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
            op_d    = sel_op;
            s_d     = sel_op;
            r_d     = ~sel_op;
            c_d     = 1'b0;
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end
        end else if (grant != 2'b00) begin
          ready_d   = grant;
          id_d      = grant[1];
          rr_last_d = grant[1];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          c_d     = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          c_d     = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        done_d    = 1'b1;
        done_id_d = id_q;
        err_d     = ~pass;
        if (pass) q_state_d = op_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RST;
      id_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      latch_C    <= 1'b0;
      latch_S    <= 1'b0;
      latch_R    <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      err        <= 1'b0;
      q_state    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rr_last_q  <= rr_last_d;
      req0_ready <= ready_d[0];
      req1_ready <= ready_d[1];
      latch_C    <= c_d;
      latch_S    <= s_d;
      latch_R    <= r_d;
      done       <= done_d;
      done_id    <= done_id_d;
      err        <= err_d;
      q_state    <= q_state_d;
    end
  end

`ifdef SR_LATCH_CTRL_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_d && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

  a_no_csr: assert property (@(posedge clk) !(latch_C && latch_S && latch_R));
  a_no_sr:  assert property (@(posedge clk) !(latch_S && latch_R));

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed and random bench for sr_latch_ctrl with a gated SR latch model and done scoreboard.
module tb_sr_latch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: default timing
  logic a_v0 = 0, a_op0 = 0, a_v1 = 0, a_op1 = 0;
  logic a_rdy0, a_rdy1, a_c, a_s, a_r, a_q, a_qb, a_done, a_did, a_err, a_qs;
  // instance b: SETUP=3 PULSE=1 HOLD=2
  logic b_v0 = 0, b_op0 = 0, b_v1 = 0, b_op1 = 0;
  logic b_rdy0, b_rdy1, b_c, b_s, b_r, b_q, b_qb, b_done, b_did, b_err, b_qs;
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
  logic [7:0] a_ecnt, b_ecnt;
`endif

  sr_latch_ctrl dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_v0), .req0_op(a_op0), .req0_ready(a_rdy0),
    .req1_valid(a_v1), .req1_op(a_op1), .req1_ready(a_rdy1),
    .latch_C(a_c), .latch_S(a_s), .latch_R(a_r), .latch_Q(a_q), .latch_Qbar(a_qb),
    .done(a_done), .done_id(a_did), .err(a_err), .q_state(a_qs)
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
    , .err_cnt(a_ecnt)
`endif
  );

  sr_latch_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_op(b_op0), .req0_ready(b_rdy0),
    .req1_valid(b_v1), .req1_op(b_op1), .req1_ready(b_rdy1),
    .latch_C(b_c), .latch_S(b_s), .latch_R(b_r), .latch_Q(b_q), .latch_Qbar(b_qb),
    .done(b_done), .done_id(b_did), .err(b_err), .q_state(b_qs)
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
    , .err_cnt(b_ecnt)
`endif
  );

  // Gated SR latch models; mode 0 = healthy, 1 = stuck Q=0/Qbar=1, 2 = Q=Qbar=1.
  int   mode_a = 0;
  logic mq_a = 1'b0, mq_b = 1'b0;
  always @(posedge clk) begin
    if (a_c && a_s && !a_r) mq_a <= 1'b1;
    else if (a_c && a_r && !a_s) mq_a <= 1'b0;
    if (b_c && b_s && !b_r) mq_b <= 1'b1;
    else if (b_c && b_r && !b_s) mq_b <= 1'b0;
  end
  always_comb begin
    a_q  = mq_a;
    a_qb = ~mq_a;
    if (mode_a == 1) begin a_q = 1'b0; a_qb = 1'b1; end
    else if (mode_a == 2) begin a_q = 1'b1; a_qb = 1'b1; end
    b_q  = mq_b;
    b_qb = ~mq_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit id;
    bit op;
    bit err;
    bit q;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (a_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(a_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_id", 32'(a_did), 32'(e.id));
        check("done_err", 32'(a_err), 32'(e.err));
        check("q_state", 32'(a_qs), 32'(e.q));
      end
    end
  end

  task automatic set_a(input bit id, input bit v, input bit op);
    if (id) begin a_v1 = v; a_op1 = op; end
    else begin a_v0 = v; a_op0 = op; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One command on instance a; wait_cyc reports negedges until its ready.
  task automatic cmd_a(input bit id, input bit op, input bit exp_err, input bit exp_q,
                       output int wait_cyc);
    int cyc, c_hi, setup;
    set_a(id, 1'b1, op);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(id ? a_rdy1 : a_rdy0) && cyc < 12);
    wait_cyc = cyc;
    check("ready_mine", 32'(id ? a_rdy1 : a_rdy0), 32'd1);
    check("ready_other", 32'(id ? a_rdy0 : a_rdy1), 32'd0);
    sb.push_back('{id, op, exp_err, exp_q});
    @(negedge clk);
    set_a(id, 1'b0, op);
    check("setup_sr", {30'd0, a_s, a_r}, {30'd0, op, ~op});
    check("setup_c", 32'(a_c), 32'd0);
    cyc = 1; c_hi = 0; setup = 1;
    while (!a_done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (a_c) c_hi++;
      else if (c_hi == 0 && (a_s || a_r)) setup++;
    end
    check("latency", cyc, 6);
    check("pulse_width", c_hi, 2);
    check("setup_len", setup, 1);
  endtask

  initial begin
    int w, cnt, exp_id;
    bit exp_op;
    repeat (3) @(negedge clk);
    check("rst_latch", {29'd0, a_c, a_s, a_r}, 32'd0);
    check("rst_ready", {30'd0, a_rdy1, a_rdy0}, 32'd0);
    check("rst_done", {29'd0, a_done, a_did, a_err}, 32'd0);
    check("rst_q", 32'(a_qs), 32'd0);

    // 1: single set from requester 0
    rst = 1'b0;
    cmd_a(1'b0, 1'b1, 1'b0, 1'b1, w);
    check("first_ready_cycle", w, 1);

    // 2: both requesters held valid, grants alternate from 0
    do_reset();
    a_v0 = 1; a_op0 = 1; a_v1 = 1; a_op1 = 0;
    exp_id = 0;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!(a_rdy0 || a_rdy1) && cnt < 12);
      check("rr_grant", {30'd0, a_rdy1, a_rdy0}, (exp_id == 1) ? 32'd2 : 32'd1);
      if (k > 0) check("rr_spacing", cnt, 7);
      exp_op = (exp_id == 0);
      sb.push_back('{exp_id[0], exp_op, 1'b0, exp_op});
      exp_id = 1 - exp_id;
    end
    @(negedge clk);
    a_v0 = 0; a_v1 = 0;
    cnt = 0;
    while (sb.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rr_drained", sb.size(), 0);

    // 3: latch stuck at 0, set fails and q_state keeps 0
    do_reset();
    mode_a = 1;
    cmd_a(1'b0, 1'b1, 1'b1, 1'b0, w);
    @(negedge clk);
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
    check("err_cnt_1", 32'(a_ecnt), 32'd1);
`endif

    // 4: latch reads Q=Qbar=1
    mode_a = 2;
    cmd_a(1'b1, 1'b1, 1'b1, 1'b0, w);
    @(negedge clk);
`ifdef SR_LATCH_CTRL_ERR_CNT_EN
    check("err_cnt_2", 32'(a_ecnt), 32'd2);
`endif
    mode_a = 0;

    // valid withdrawn while ready is offered: nothing happens
    a_v0 = 1; a_op0 = 1;
    @(negedge clk);
    check("drop_ready", 32'(a_rdy0), 32'd1);
    a_v0 = 0;
    repeat (10) @(negedge clk);
    check("drop_idle", {29'd0, a_c, a_s, a_r}, 32'd0);
    check("drop_q", 32'(a_qs), 32'd0);

    // 5: reset during the gate pulse
    a_v0 = 1; a_op0 = 1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!a_rdy0 && cnt < 12);
    @(negedge clk);
    a_v0 = 0;
    cnt = 0;
    while (!a_c && cnt < 10) begin @(negedge clk); cnt++; end
    check("pulse_reached", 32'(a_c), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_latch", {29'd0, a_c, a_s, a_r}, 32'd0);
    check("abort_ready", {30'd0, a_rdy1, a_rdy0}, 32'd0);
    rst = 1'b0;
    cmd_a(1'b1, 1'b1, 1'b0, 1'b1, w);
    check("after_abort_ready_cycle", w, 1);

    // 6: alternate timing on instance b, random commands
    for (int i = 0; i < 1000; i++) begin
      bit id, op;
      int c_hi, setup;
      id = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      if (id) begin b_v1 = 1; b_op1 = op; end else begin b_v0 = 1; b_op0 = op; end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!(id ? b_rdy1 : b_rdy0) && cnt < 12);
      check("b_ready", 32'(id ? b_rdy1 : b_rdy0), 32'd1);
      @(negedge clk);
      b_v0 = 0; b_v1 = 0;
      cnt = 1; c_hi = 0; setup = 1;
      while (!b_done && cnt < 30) begin
        @(negedge clk);
        cnt++;
        if (b_c) c_hi++;
        else if (c_hi == 0 && (b_s || b_r)) setup++;
      end
      check("b_latency", cnt, 8);
      check("b_pulse", c_hi, 1);
      check("b_setup", setup, 3);
      check("b_done", {29'd0, b_did, b_err, b_qs}, {29'd0, id, 1'b0, op});
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
